// File: rtl/reg_file_wb_pkg.sv
// Shared CPU constants: register-file geometry, special register indices and
// the write-destination selector encodings used by the selector and the register file.
package cpu_defs_pkg;

    localparam int          REG_NUM    = 32;
    localparam int          REG_ADDR_W = 5;
    localparam int          DATA_W     = 32;

    localparam logic [4:0]  REG_ZERO   = 5'd0;
    localparam logic [4:0]  REG_RA     = 5'd31;

    typedef enum logic [1:0] {
        DST_RD = 2'b00,
        DST_RT = 2'b01,
        DST_RA = 2'b10
    } wb_dst_e;

endpackage

// File: rtl/reg_file_wb_read_port.sv
// One combinational register-file read port: index mux, r0 forced to zero and,
// when REGFILE_BYPASS_EN is defined, write-first forwarding of the write-back data.
module regfile_read_port
    import cpu_defs_pkg::REG_ZERO;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs_i,
    input  logic [ADDR_W-1:0]                raddr_i,
    input  logic                             we_i,
    input  logic [ADDR_W-1:0]                waddr_i,
    input  logic [DATA_W-1:0]                wdata_i,
    output logic [DATA_W-1:0]                rdata_o
);

`ifndef REGFILE_BYPASS_EN
    logic unused_wr_sigs;
    assign unused_wr_sigs = ^{we_i, waddr_i, wdata_i};
`endif

    always_comb begin
        rdata_o = regs_i[raddr_i];
`ifdef REGFILE_BYPASS_EN
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end
`endif
        // Zero-forcing comes last so index 0 never forwards either.
        if (raddr_i == REG_ZERO) begin
            rdata_o = '0;
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// 32x32 MIPS general-purpose register file: one write port, three async read ports
// (rs, rt, debug). Optional write-first forwarding with macro REGFILE_BYPASS_EN.
module reg_file_wb
    import cpu_defs_pkg::REG_ZERO;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 5,
    parameter logic [DATA_W-1:0] RESET_VAL = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NUM_REGS  = 2**ADDR_W;
    localparam int NUM_PORTS = 3;

    logic                                  wr_en;
    logic [NUM_REGS-1:0][DATA_W-1:0]       regs_flat;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]      port_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0]      port_data;

    assign wr_en = we && (waddr != REG_ZERO);

    // Entry 0 has no storage at all; it is a hard-wired zero.
    assign regs_flat[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] reg_q;
            logic [DATA_W-1:0] reg_d;

            always_comb begin
                reg_d = reg_q;
                if (wr_en && (waddr == ADDR_W'(gi))) begin
                    reg_d = wdata;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    reg_q <= RESET_VAL;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs_flat[gi] = reg_q;
        end
    endgenerate

    assign port_addr = {dbg_addr, raddr2, raddr1};

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rport
            regfile_read_port #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_rport (
                .regs_i  (regs_flat),
                .raddr_i (port_addr[gi]),
                .we_i    (we),
                .waddr_i (waddr),
                .wdata_i (wdata),
                .rdata_o (port_data[gi])
            );
        end
    endgenerate

    assign rdata1   = port_data[0];
    assign rdata2   = port_data[1];
    assign dbg_data = port_data[2];

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against an array-based model.
module tb_reg_file_wb;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    logic [31:0] model [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file_wb dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of a read: r0 is zero, otherwise the last committed
    // value, or the in-flight write-back data when forwarding is built in.
    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYPASS && we && (waddr == a)) return wdata;
        return model[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata1", rdata1, expect_rd(raddr1));
            chk("rdata2", rdata2, expect_rd(raddr2));
            chk("dbg_data", dbg_data, expect_rd(dbg_addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hAAAA_AAAA;
        raddr1 = 5'd3; raddr2 = 5'd0; dbg_addr = 5'd0;
        step();
        chk_en = 1'b1;
        rst = 1'b0; we = 1'b0;

        // Reset: every index reads zero, the write during reset was dropped.
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #2;
            chk($sformatf("reset_r%0d", i), dbg_data, 32'h0);
            step();
        end

        // Basic writes on consecutive edges.
        we = 1'b1; waddr = 5'd8; wdata = 32'hDEAD_BEEF;
        step();
        waddr = 5'd9; wdata = 32'h1234_5678; raddr1 = 5'd8;
        #2;
        chk("basic_r8", rdata1, 32'hDEAD_BEEF);
        step();
        we = 1'b0; raddr2 = 5'd9;
        #2;
        chk("basic_r9", rdata2, 32'h1234_5678);
        chk("basic_r8_hold", rdata1, 32'hDEAD_BEEF);

        // Writes to r0 are ignored, also in the forwarding build.
        step();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
        #2;
        chk("zero_same_cycle", rdata1, 32'h0);
        step();
        we = 1'b0;
        #2;
        chk("zero_after", rdata1, 32'h0);

        // jal link write to r31.
        step();
        we = 1'b1; waddr = 5'd31; wdata = 32'h0040_0010;
        step();
        we = 1'b0; raddr1 = 5'd31; raddr2 = 5'd30; dbg_addr = 5'd0;
        #2;
        chk("jal_r31", rdata1, 32'h0040_0010);
        chk("jal_r30", rdata2, 32'h0);
        chk("jal_r0", dbg_data, 32'h0);

        // Same-cycle read of the register being written.
        step();
        we = 1'b1; waddr = 5'd5; wdata = 32'h1;
        step();
        wdata = 32'h2; raddr1 = 5'd5;
        #2;
        chk("rw_same_cycle", rdata1, BYPASS ? 32'h2 : 32'h1);
        step();
        we = 1'b0;
        #2;
        chk("rw_after_edge", rdata1, 32'h2);

        // Randomized traffic, including occasional resets.
        for (int c = 0; c < 1500; c++) begin
            step();
            rst      = ($urandom_range(0, 63) == 0);
            we       = $urandom_range(0, 3) != 0;
            waddr    = 5'($urandom_range(0, 31));
            wdata    = $urandom;
            raddr1   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            dbg_addr = 5'($urandom_range(0, 31));
        end

        // Mid-run reset wipes a fully populated file.
        step();
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i);
            step();
        end
        we = 1'b0; dbg_addr = 5'd17;
        #2;
        chk("fill_r17", dbg_data, 32'd17);
        step();
        rst = 1'b1; we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_0007;
        step();
        rst = 1'b0; we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #2;
            chk($sformatf("midrst_r%0d", i), dbg_data, 32'h0);
            step();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32x32-bit general-purpose register file for the 31-instruction single-cycle MIPS CPU.
- Consumes the 5-bit destination index from the write-destination selector, which chooses rd, rt or 31 ($ra for jal), together with the write-back data.
- Serves the two decode-stage source reads (rs, rt).
- Holds all architectural integer state; sits between the decode stage and the write-back stage.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, index width; depth is 2**ADDR_W = 32 entries.
- RESET_VAL, 32'h0000_0000, value loaded into every register on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable from control unit.
- waddr  input  ADDR_W  destination index from the write-destination selector (rd / rt / 31).
- wdata  input  DATA_W  write-back data (ALU result, memory data or PC+4 for jal).
- raddr1  input  ADDR_W  rs index.
- raddr2  input  ADDR_W  rt index.
- rdata1  output  DATA_W  contents of register raddr1.
- rdata2  output  DATA_W  contents of register raddr2.
- dbg_addr  input  ADDR_W  debug/testbench read index.
- dbg_data  output  DATA_W  contents of register dbg_addr.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled only on the rising clk edge.
- Reset:
  - On a rising edge with rst=1, all 32 registers load RESET_VAL.
  - Any write presented in the same cycle is discarded; reset has priority over we.
  - Outputs are combinational reads, so rdata1, rdata2 and dbg_data read RESET_VAL from the cycle after the reset edge.
  - Reset asserted mid-program clears everything on that edge; no partial state survives.
- Write:
  - On a rising edge with rst=0, we=1 and waddr!=0: reg[waddr] <= wdata.
  - Latency is 1 cycle: the new value is visible on the read ports after the edge.
  - we=0 leaves all registers unchanged.
- Register 0:
  - Writes to index 0 are ignored.
  - reg[0] always reads 32'h0 regardless of RESET_VAL or write history.
  - Implementation either never stores to entry 0 or forces the read mux to 0; both must hold.
- Read:
  - Three independent asynchronous (combinational) read ports.
  - Same address on multiple ports is legal; all return identical data.
  - Read of waddr during a write cycle returns the OLD value unless REGFILE_BYPASS_EN is defined.
- Index 31:
  - No special casing. A jal write (waddr=31, wdata=PC+4) behaves as any other write.
  - Any index is a valid 5-bit value, so no X or Z is ever driven on rdata.
- There is no write-after-write conflict: only one write port exists.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: internal write-first forwarding. If we=1, waddr!=0 and raddrN==waddr, rdataN = wdata combinationally in the same cycle. This applies to rdata1, rdata2 and dbg_data. Intended for pipelined reuse where write-back and decode share a cycle.
- Undefined: pure read-before-write. Reads always reflect register contents as of the last edge.
- Index 0 never bypasses in either build.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - REG_NUM=32, REG_ADDR_W=5, DATA_W=32.
  - REG_ZERO=5'd0, REG_RA=5'd31.
  - The write-destination select encodings: DST_RD=2'b00, DST_RT=2'b01, DST_RA=2'b10.
- The selector and this block share these constants.
- One natural sub-module: regfile_read_port. It is instantiated three times and handles zero-forcing plus the optional bypass compare.

Test Plan:
- Reset then read: assert rst for 1 edge -> all 32 indices via dbg_addr read 0x00000000; a write with we=1 in the reset cycle is not committed.
- Basic write/read: write 0xDEADBEEF to r8, 0x12345678 to r9 on consecutive edges -> raddr1=8, raddr2=9 give those values the cycle after each write.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1 at raddr1=0 stays 0x0, including with REGFILE_BYPASS_EN defined.
- jal link: waddr=31 (DST_RA path), wdata=0x00400010 -> r31 reads 0x00400010; r30 and r0 are unchanged.
- Same-cycle read/write: r5=0x1, then write 0x2 to r5 with raddr1=5:
  - Without macro, rdata1=0x1 before the edge and 0x2 after.
  - With macro, rdata1=0x2 immediately.
- Mid-run reset: fill r1..r31 with their index values, then assert rst with we=1 to r7 -> every register reads 0 next cycle.
